// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: mux select codes,
// the "operand not read" Tuse marker and the Tnew value of each instruction class.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  // D-stage mux codes; the E-stage mux reuses 01/10 for its M/W inputs
  localparam fwd_sel_t FWD_GRF = 2'b00;
  localparam fwd_sel_t FWD_E   = 2'b01;
  localparam fwd_sel_t FWD_M   = 2'b10;
  localparam fwd_sel_t FWD_W   = 2'b11;

  localparam int TUSE_NONE = 3;

  localparam int TNEW_LINK = 0;
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;

endpackage

// File: rtl/hazard_match.sv
// Resolves one source operand against the E/M/W scoreboard entries:
// raises a stall bit when a pending writer is too late, and picks the
// forwarding select from the newest matching stage.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int TW     = 2,
  parameter bit E_SIDE = 1'b0
) (
  input  logic [4:0]    r_i,
  input  logic [TW-1:0] tuse_i,
  input  logic [4:0]    e_wa_i,
  input  logic [TW-1:0] e_tnew_i,
  input  logic [4:0]    m_wa_i,
  input  logic [TW-1:0] m_tnew_i,
  input  logic [4:0]    w_wa_i,
  input  logic [TW-1:0] w_tnew_i,
  output logic          stall_o,
  output fwd_sel_t      sel_o
);

  // The E-stage mux has no E input, so its M/W codes shift down by one
  localparam fwd_sel_t CODE_E = FWD_E;
  localparam fwd_sel_t CODE_M = E_SIDE ? FWD_E : FWD_M;
  localparam fwd_sel_t CODE_W = E_SIDE ? FWD_M : FWD_W;

  logic e_hit, m_hit, w_hit;

  // Register 0 is hard-wired and never matches a writer
  assign e_hit = (r_i != 5'd0) && (e_wa_i == r_i);
  assign m_hit = (r_i != 5'd0) && (m_wa_i == r_i);
  assign w_hit = (r_i != 5'd0) && (w_wa_i == r_i);

  // Stall when a matching writer in E or M will not have its result in time
  always_comb begin
    stall_o = 1'b0;
    if (!E_SIDE) begin
      stall_o = (e_hit && (e_tnew_i > tuse_i)) ||
                (m_hit && (m_tnew_i > tuse_i));
    end
  end

  // Newest matching stage decides; a pending newest writer blocks older forwards
  always_comb begin
    sel_o = FWD_GRF;
    if (e_hit) begin
      if (e_tnew_i == '0) sel_o = CODE_E;
    end else if (m_hit) begin
      if (m_tnew_i == '0) sel_o = CODE_M;
    end else if (w_hit) begin
      if (w_tnew_i == '0) sel_o = CODE_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline. Tracks the
// destination and Tnew countdown of the instructions in E, M and W, and
// derives the D-stage stall plus the D/E forwarding selects combinationally.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    D_rs,
  input  logic [4:0]    D_rt,
  input  logic [TW-1:0] D_Tuse_rs,
  input  logic [TW-1:0] D_Tuse_rt,
  input  logic [4:0]    D_wa,
  input  logic [TW-1:0] D_Tnew,
  output logic          stall,
  output logic [1:0]    FwdD_rs,
  output logic [1:0]    FwdD_rt,
  output logic [1:0]    FwdE_rs,
  output logic [1:0]    FwdE_rt
);

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  logic [4:0]    e_rs_q, e_rt_q, e_wa_q, m_wa_q, w_wa_q;
  logic [TW-1:0] e_tnew_q, m_tnew_q, w_tnew_q;
  logic [4:0]    e_rs_d, e_rt_d, e_wa_d, m_wa_d, w_wa_d;
  logic [TW-1:0] e_tnew_d, m_tnew_d, w_tnew_d;

  logic st_d_rs, st_d_rt, st_e_rs, st_e_rt;

  // Scoreboard advance: countdown on each hop, bubble into E while stalled
  always_comb begin
    m_wa_d   = e_wa_q;
    m_tnew_d = sat_dec(e_tnew_q);
    w_wa_d   = m_wa_q;
    w_tnew_d = sat_dec(m_tnew_q);
    e_rs_d   = 5'd0;
    e_rt_d   = 5'd0;
    e_wa_d   = 5'd0;
    e_tnew_d = '0;
    if (!stall) begin
      e_rs_d   = D_rs;
      e_rt_d   = D_rt;
      e_wa_d   = D_wa;
      e_tnew_d = D_Tnew;
    end
  end

  // Scoreboard registers; reset also discards a bubble that was pending
  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_wa_q   <= 5'd0;
      e_tnew_q <= '0;
      m_wa_q   <= 5'd0;
      m_tnew_q <= '0;
      w_wa_q   <= 5'd0;
      w_tnew_q <= '0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      m_wa_q   <= m_wa_d;
      m_tnew_q <= m_tnew_d;
      w_wa_q   <= w_wa_d;
      w_tnew_q <= w_tnew_d;
    end
  end

  hazard_match #(.TW(TW), .E_SIDE(1'b0)) u_d_rs (
    .r_i(D_rs), .tuse_i(D_Tuse_rs),
    .e_wa_i(e_wa_q), .e_tnew_i(e_tnew_q),
    .m_wa_i(m_wa_q), .m_tnew_i(m_tnew_q),
    .w_wa_i(w_wa_q), .w_tnew_i(w_tnew_q),
    .stall_o(st_d_rs), .sel_o(FwdD_rs)
  );

  hazard_match #(.TW(TW), .E_SIDE(1'b0)) u_d_rt (
    .r_i(D_rt), .tuse_i(D_Tuse_rt),
    .e_wa_i(e_wa_q), .e_tnew_i(e_tnew_q),
    .m_wa_i(m_wa_q), .m_tnew_i(m_tnew_q),
    .w_wa_i(w_wa_q), .w_tnew_i(w_tnew_q),
    .stall_o(st_d_rt), .sel_o(FwdD_rt)
  );

  // E-stage operands only look at older stages, so the E entry is masked off
  hazard_match #(.TW(TW), .E_SIDE(1'b1)) u_e_rs (
    .r_i(e_rs_q), .tuse_i(TW'(TUSE_NONE)),
    .e_wa_i(5'd0), .e_tnew_i('0),
    .m_wa_i(m_wa_q), .m_tnew_i(m_tnew_q),
    .w_wa_i(w_wa_q), .w_tnew_i(w_tnew_q),
    .stall_o(st_e_rs), .sel_o(FwdE_rs)
  );

  hazard_match #(.TW(TW), .E_SIDE(1'b1)) u_e_rt (
    .r_i(e_rt_q), .tuse_i(TW'(TUSE_NONE)),
    .e_wa_i(5'd0), .e_tnew_i('0),
    .m_wa_i(m_wa_q), .m_tnew_i(m_tnew_q),
    .w_wa_i(w_wa_q), .w_tnew_i(w_tnew_q),
    .stall_o(st_e_rt), .sel_o(FwdE_rt)
  );

  // E-side stall bits are constant 0; OR-ing them in keeps every output consumed
  assign stall = st_d_rs | st_d_rt | st_e_rs | st_e_rt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each cycle's stimulus pushes its expected
// outputs into a queue, and a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_wa;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       stall;
  logic [1:0] FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt;

  typedef struct {
    logic       st;
    logic [1:0] drs;
    logic [1:0] drt;
    logic [1:0] ers;
    logic [1:0] ert;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl #(.TW(2)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_wa(D_wa), .D_Tnew(D_Tnew),
    .stall(stall),
    .FwdD_rs(FwdD_rs), .FwdD_rt(FwdD_rt),
    .FwdE_rs(FwdE_rs), .FwdE_rt(FwdE_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input string field,
                       input logic [1:0] act, input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %b want %b", name, field, act, req);
    end
  endtask

  // Monitor: outputs are live every cycle, compare whenever an expectation is queued
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, "stall",   {1'b0, stall}, {1'b0, e.st});
      check(e.name, "FwdD_rs", FwdD_rs, e.drs);
      check(e.name, "FwdD_rt", FwdD_rt, e.drt);
      check(e.name, "FwdE_rs", FwdE_rs, e.ers);
      check(e.name, "FwdE_rt", FwdE_rt, e.ert);
    end
  end

  task automatic issue(input logic rst,
                       input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic [4:0] wa, input logic [1:0] tn,
                       input logic xst, input logic [1:0] xdrs, input logic [1:0] xdrt,
                       input logic [1:0] xers, input logic [1:0] xert,
                       input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    D_rs      = rs;
    D_Tuse_rs = tur;
    D_rt      = rt;
    D_Tuse_rt = tut;
    D_wa      = wa;
    D_Tnew    = tn;
    e.st = xst; e.drs = xdrs; e.drt = xdrt; e.ers = xers; e.ert = xert; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic nop(input string name, input logic [1:0] xers, input logic [1:0] xert);
    issue(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'b00, 2'b00, xers, xert, name);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    D_rs = 5'd0; D_rt = 5'd0; D_wa = 5'd0;
    D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_Tnew = 2'd0;

    // reset held, then a writer appears in D against an empty scoreboard
    issue(1, 0,3, 0,3, 5,1, 0, 2'b00,2'b00,2'b00,2'b00, "rst_hold1");
    issue(1, 0,3, 0,3, 5,1, 0, 2'b00,2'b00,2'b00,2'b00, "rst_hold2");
    issue(0, 0,3, 0,3, 5,1, 0, 2'b00,2'b00,2'b00,2'b00, "post_rst");
    nop("post_rst_nop1", 2'b00, 2'b00);
    nop("post_rst_nop2", 2'b00, 2'b00);
    nop("post_rst_nop3", 2'b00, 2'b00);

    // load-use: lw $8 (Tnew 2) then add reading $8 at Tuse 1
    issue(0, 0,3, 0,3, 8,2, 0, 2'b00,2'b00,2'b00,2'b00, "lu_lw");
    issue(0, 8,1, 0,3, 9,1, 1, 2'b00,2'b00,2'b00,2'b00, "lu_stall");
    issue(0, 8,1, 0,3, 9,1, 0, 2'b00,2'b00,2'b00,2'b00, "lu_go");
    nop("lu_fwdE_W", 2'b10, 2'b00);
    nop("lu_nop1", 2'b00, 2'b00);
    nop("lu_nop2", 2'b00, 2'b00);

    // ALU result feeding a branch at Tuse 0
    issue(0, 0,3, 0,3, 3,1, 0, 2'b00,2'b00,2'b00,2'b00, "br_add");
    issue(0, 3,0, 0,3, 0,0, 1, 2'b00,2'b00,2'b00,2'b00, "br_stall");
    issue(0, 3,0, 0,3, 0,0, 0, 2'b10,2'b00,2'b00,2'b00, "br_fwdM");
    nop("br_fwdE_W", 2'b10, 2'b00);
    nop("br_nop", 2'b00, 2'b00);

    // writes to $0 are invisible
    issue(0, 0,3, 0,3, 0,2, 0, 2'b00,2'b00,2'b00,2'b00, "z_wr0");
    issue(0, 0,0, 0,3, 0,0, 0, 2'b00,2'b00,2'b00,2'b00, "z_rd0_a");
    issue(0, 0,0, 0,3, 0,0, 0, 2'b00,2'b00,2'b00,2'b00, "z_rd0_b");

    // newest writer wins: M and W both write $4
    issue(0, 0,3, 0,3, 4,0, 0, 2'b00,2'b00,2'b00,2'b00, "nw_link");
    issue(0, 0,3, 0,3, 4,1, 0, 2'b00,2'b00,2'b00,2'b00, "nw_alu");
    nop("nw_nop1", 2'b00, 2'b00);
    issue(0, 0,3, 4,0, 0,0, 0, 2'b00,2'b10,2'b00,2'b00, "nw_Mwins");
    issue(0, 0,3, 0,3, 4,1, 0, 2'b00,2'b00,2'b00,2'b10, "nw_fwdE_W");
    issue(0, 0,3, 0,3, 4,2, 0, 2'b00,2'b00,2'b00,2'b00, "nw_lw");
    nop("nw_nop2", 2'b00, 2'b00);
    issue(0, 0,3, 4,0, 0,0, 1, 2'b00,2'b00,2'b00,2'b00, "nw_Mpend");
    issue(0, 0,3, 4,0, 0,0, 0, 2'b00,2'b11,2'b00,2'b00, "nw_fwdW");
    nop("nw_nop3", 2'b00, 2'b00);
    nop("nw_nop4", 2'b00, 2'b00);

    // reset asserted while a load-use stall is in progress
    issue(0, 0,3, 0,3, 7,2, 0, 2'b00,2'b00,2'b00,2'b00, "rs_lw");
    issue(1, 7,1, 0,3, 0,0, 1, 2'b00,2'b00,2'b00,2'b00, "rs_stall");
    issue(0, 7,1, 0,3, 0,0, 0, 2'b00,2'b00,2'b00,2'b00, "rs_empty");
    nop("rs_no_lw", 2'b00, 2'b00);

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
